// File: rtl/game_fsm.sv
// Frogger game state controller: start debounce, IDLE/RUNNING/P1_WINS/CLEANUP sequencing, lives.
// Define GAME_FSM_BLINK_EN to blink the lives LEDs during invulnerability and after a loss.
module game_fsm #(
    parameter int unsigned c_LIVES          = 3,
    parameter int unsigned c_DEBOUNCE       = 250000,
    parameter int unsigned c_RESPAWN_CYCLES = 25000000,
    parameter int unsigned c_WIN_SCORE      = 10
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [6:0] i_Score,
    output logic [1:0] o_State,
    output logic       o_Game_Active,
    output logic       o_Respawn,
    output logic       o_Invuln,
    output logic [1:0] o_Lives,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_P1_WINS = 2'b10;
    localparam logic [1:0] ST_CLEANUP = 2'b11;

    localparam int unsigned DB_W  = $clog2(c_DEBOUNCE + 1);
    localparam int unsigned TMR_W = $clog2(c_RESPAWN_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(c_DEBOUNCE - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(c_RESPAWN_CYCLES - 1);
    localparam logic [7:0]       WIN_SCORE  = 8'(c_WIN_SCORE);
    localparam logic [1:0]       LIVES_INIT = 2'(c_LIVES);
    localparam logic [2:0]       LEDS_INIT  = {c_LIVES >= 32'd3, c_LIVES >= 32'd2,
                                               c_LIVES >= 32'd1};

    logic            sync1_q, sync2_q;
    logic            db_level_q, db_prev_q, start_pulse_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            col_prev_q;

    logic [1:0]       state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic             invuln_q, invuln_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             respawn_q, respawn_d;
    logic             active_q;
    logic [2:0]       leds_q, leds_d, therm_d;

    logic start_evt, col_evt, win;

    assign start_evt = start_pulse_q;
    assign col_evt   = i_Collided & ~col_prev_q;
    assign win       = ({1'b0, i_Score} >= WIN_SCORE);

    // Start button: synchronize, debounce, then one registered pulse per debounced rise.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_level_q    <= 1'b0;
            db_cnt_q      <= '0;
            db_prev_q     <= 1'b0;
            start_pulse_q <= 1'b0;
            col_prev_q    <= 1'b0;
        end else begin
            sync1_q       <= i_Game_Start;
            sync2_q       <= sync1_q;
            db_prev_q     <= db_level_q;
            start_pulse_q <= db_level_q & ~db_prev_q;
            col_prev_q    <= i_Collided;
            if (sync2_q != db_level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_level_q <= sync2_q;
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // timer_q counts down the invulnerability window in RUNNING and up the dwell in CLEANUP.
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        invuln_d  = invuln_q;
        timer_d   = timer_q;
        respawn_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lives_d  = LIVES_INIT;
                invuln_d = 1'b0;
                timer_d  = '0;
                if (start_evt) begin
                    state_d   = ST_RUNNING;
                    respawn_d = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (invuln_q) begin
                    if (timer_q == '0) invuln_d = 1'b0;
                    else               timer_d  = timer_q - TMR_W'(1);
                end
                if (win) begin
                    state_d  = ST_P1_WINS;
                    invuln_d = 1'b0;
                    timer_d  = '0;
                end else if (col_evt && !invuln_q) begin
                    if (lives_q <= 2'd1) begin
                        lives_d  = 2'd0;
                        state_d  = ST_CLEANUP;
                        invuln_d = 1'b0;
                        timer_d  = '0;
                    end else begin
                        lives_d   = lives_q - 2'd1;
                        respawn_d = 1'b1;
                        invuln_d  = 1'b1;
                        timer_d   = TMR_LAST;
                    end
                end
            end
            ST_P1_WINS: begin
                if (start_evt) begin
                    state_d = ST_CLEANUP;
                    timer_d = '0;
                end
            end
            ST_CLEANUP: begin
                if (timer_q == TMR_LAST) begin
                    state_d = ST_IDLE;
                    lives_d = LIVES_INIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
        endcase
    end

`ifdef GAME_FSM_BLINK_EN
    logic [20:0] blink_q, blink_d;
    assign blink_d = blink_q + 21'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) blink_q <= '0;
        else          blink_q <= blink_d;
    end
`endif

    always_comb begin
        therm_d = {lives_d >= 2'd3, lives_d >= 2'd2, lives_d >= 2'd1};
        leds_d  = therm_d;
`ifdef GAME_FSM_BLINK_EN
        // Phase bit low means lit, so the first half-period after reset shows the LEDs on.
        if (invuln_d) begin
            leds_d = therm_d & {3{~blink_d[20]}};
        end else if (state_d == ST_CLEANUP && lives_d == 2'd0) begin
            leds_d = {3{~blink_d[20]}};
        end
`endif
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_INIT;
            invuln_q  <= 1'b0;
            timer_q   <= '0;
            respawn_q <= 1'b0;
            active_q  <= 1'b0;
            leds_q    <= LEDS_INIT;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            invuln_q  <= invuln_d;
            timer_q   <= timer_d;
            respawn_q <= respawn_d;
            active_q  <= (state_d == ST_RUNNING);
            leds_q    <= leds_d;
        end
    end

    assign o_State       = state_q;
    assign o_Game_Active = active_q;
    assign o_Respawn     = respawn_q;
    assign o_Invuln      = invuln_q;
    assign o_Lives       = lives_q;
    assign o_LED_2       = leds_q[0];
    assign o_LED_3       = leds_q[1];
    assign o_LED_4       = leds_q[2];

endmodule

// File: doc/game_fsm.md
# game_fsm

Top-level game state controller for Frogger. Sits directly upstream of the game renderer and `frogger_ctrl`, and downstream of `frogger_collisions`. It debounces the start button, sequences IDLE/RUNNING/P1_WINS/CLEANUP, counts lives on collision events and requests frog respawns. It drives the game-active flag and the lives LEDs.

## Interface
- `c_LIVES`, 3: lives loaded on entry to IDLE (1..3).
- `c_DEBOUNCE`, 250000: cycles the synchronized start input must be stable to be accepted.
- `c_RESPAWN_CYCLES`, 25000000: length of the post-hit invulnerability window, and of the CLEANUP dwell.
- `c_WIN_SCORE`, 10: score at or above which RUNNING moves to P1_WINS.
- `i_Clk` input 1: system clock (25 MHz pixel clock).
- `i_Rst_L` input 1: asynchronous, active-low reset.
- `i_Game_Start` input 1: raw start button, active high, asynchronous to `i_Clk`.
- `i_Collided` input 1: collision level from `frogger_collisions`, synchronous.
- `i_Score` input 7: current score from `frogger_ctrl`, unsigned.
- `o_State` output 2: 00 IDLE, 01 RUNNING, 10 P1_WINS, 11 CLEANUP.
- `o_Game_Active` output 1: high only in RUNNING.
- `o_Respawn` output 1: one-cycle pulse; `frogger_ctrl` returns the frog to its origin.
- `o_Invuln` output 1: high during the invulnerability window.
- `o_Lives` output 2: remaining lives.
- `o_LED_2`, `o_LED_3`, `o_LED_4` output 1 each: thermometer lives display. LED_2 = lives≥1, LED_3 = lives≥2, LED_4 = lives≥3.

## Operation
- **Start input path**
  - 2-FF synchronizer, then debounce counter.
  - The debounced level updates when the synchronized value has differed from it for `c_DEBOUNCE` consecutive cycles. Any bounce restarts the count.
  - Start event is a one-cycle pulse on a debounced 0→1 transition.
- **Collision event:** `i_Collided`=1 while the previous-cycle sample was 0. A held-high level yields exactly one event.
- **IDLE**
  - lives = `c_LIVES`, invulnerability cleared.
  - Start event → RUNNING, and `o_Respawn` pulses.
- **RUNNING, win check:** `i_Score` ≥ `c_WIN_SCORE` → P1_WINS. Win takes priority over a same-cycle collision; lives are unchanged.
- **RUNNING, collision while not invulnerable:**
  - If lives = 1: lives → 0, state → CLEANUP, no respawn.
  - Otherwise: lives decrements, `o_Respawn` pulses, invulnerability counter loads `c_RESPAWN_CYCLES`-1, `o_Invuln`=1.
- **RUNNING, collision while invulnerable:** ignored.
- **Invulnerability window:** counter decrements each cycle. `o_Invuln` drops on the cycle after the counter reaches 0.
- **P1_WINS:** game inactive. A start event → CLEANUP.
- **CLEANUP**
  - Dwell counter runs `c_RESPAWN_CYCLES` cycles, then → IDLE, with lives reloading on IDLE entry.
  - Start events and collisions are ignored.
- Leaving RUNNING clears invulnerability immediately.
- Start events in RUNNING are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `o_State`=IDLE, `o_Game_Active`=0, `o_Respawn`=0, `o_Invuln`=0.
  - `o_Lives`=`c_LIVES`, LEDs per `c_LIVES`.
  - Synchronizer, debounce, collision sample and all counters = 0.
- Start latency: button press → start pulse = 2 (sync) + `c_DEBOUNCE` + 1 cycles. The state changes on the edge after the pulse.
- Collision latency: `i_Collided` rises at edge N. `o_Lives`, `o_Respawn` and `o_Invuln` change at edge N+1. `o_Respawn` deasserts at N+2.
- Invulnerability: `o_Invuln` is high for exactly `c_RESPAWN_CYCLES` cycles.
- CLEANUP → IDLE after exactly `c_RESPAWN_CYCLES` cycles in CLEANUP.
- Reset asserted mid-game, mid-debounce or mid-window returns immediately to reset values. Deassertion is not synchronized internally; the top level supplies a synchronized release.
- A lives counter at 0 never decrements; it does not wrap.

## Configuration
- `GAME_FSM_BLINK_EN` defined:
  - While `o_Invuln`=1, lit lives LEDs toggle every 2^20 cycles, driven by a free-running 21-bit counter reset to 0 with phase starting lit.
  - In CLEANUP after a loss, all LEDs blink the same way.
- Not defined: LEDs are a steady thermometer of `o_Lives`, and the blink counter is absent.

## Test plan
Bench parameters: `c_DEBOUNCE`=4, `c_RESPAWN_CYCLES`=8, `c_WIN_SCORE`=3, `c_LIVES`=3.
- Release reset, hold start high 10 cycles → start pulse 7 cycles after rise; `o_State`=01, `o_Respawn` high 1 cycle, `o_Lives`=3.
- Start bouncing 1,0,1,0 every 2 cycles, then low → no state change, `o_State` stays 00.
- RUNNING, `i_Collided` high 20 cycles → one decrement to `o_Lives`=2, one `o_Respawn` pulse, `o_Invuln` high exactly 8 cycles.
- Three collisions spaced 12 cycles apart → lives 2, 1, 0; third gives `o_State`=11 with no respawn, then 00 after 8 cycles with `o_Lives`=3.
- `i_Score`=3 and collision in the same cycle → `o_State`=10, `o_Lives` unchanged; next start pulse → 11, then 00 after 8 cycles.
- Assert `i_Rst_L`=0 mid-invulnerability → same cycle `o_State`=00, `o_Invuln`=0, `o_Lives`=3.
